// File: rtl/fp_conv_pkg.sv
// Shared types and constants for the half-float <-> fix(8.8) conversion stages.
// Both Program 1 (fix-to-float) and Program 2 (float-to-fix) import this package.
package fp_conv_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_LO,
        RD_HI,
        DECODE,
        SHIFT,
        NEG,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    localparam int unsigned FP_BIAS  = 15;
    localparam int unsigned FIX_FRAC = 8;
    localparam int unsigned MANT_W   = 10;
    localparam logic [15:0] FIX_MAX  = 16'h7FFF;
    localparam logic [15:0] FIX_MIN  = 16'h8000;
    // Exponent where {1,m} already sits at the fix(8.8) binary point,
    // and the first exponent whose value no longer fits in fix(8.8).
    localparam int unsigned E_UNITY  = FP_BIAS + MANT_W - FIX_FRAC;
    localparam int unsigned E_SAT    = 22;

endpackage

// File: rtl/float_to_fix_conv_if.sv
// Start/done handshake and byte-wide data memory port of the conversion stage.
interface float_to_fix_conv_if;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    modport master (
        output start,
        output mem_rdata,
        input  done,
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wdata
    );

    modport slave (
        input  start,
        input  mem_rdata,
        output done,
        output mem_addr,
        output mem_wr_en,
        output mem_wdata
    );
endinterface

// File: rtl/float_to_fix_conv.sv
// Reads an IEEE-754 half float from memory, converts it to signed fix(8.8) with
// truncation toward zero and saturation, and writes the result back.
module float_to_fix_conv
    import fp_conv_pkg::*;
#(
    parameter logic [7:0] SRC_ADDR = 8'd2,
    parameter logic [7:0] DST_ADDR = 8'd4
) (
    input  logic                clk,
    input  logic                reset,
    float_to_fix_conv_if.slave  bus
);

    localparam logic [4:0] E_UNITY_5 = 5'(E_UNITY);
    localparam logic [4:0] E_SAT_5   = 5'(E_SAT);
    // Below this exponent even the hidden bit is shifted out entirely.
    localparam logic [4:0] E_MIN_5   = 5'(E_UNITY - MANT_W);

    state_t      state_q, state_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] mag_q, mag_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        left_q, left_d;
    logic        sat_q, sat_d;
    logic        sgn_q, sgn_d;
    logic [15:0] res_q, res_d;
    logic        done_q, done_d;
    logic [7:0]  addr_q, addr_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [15:0] f;
    logic [4:0]  e;

    function automatic logic [15:0] fix_result(input logic sat, input logic s,
                                               input logic [15:0] mag);
        if (sat)
            return s ? FIX_MIN : FIX_MAX;
        return s ? (~mag + 16'd1) : mag;
    endfunction

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        sat_d   = sat_q;
        sgn_d   = sgn_q;
        res_d   = res_q;
        done_d  = done_q;
        addr_d  = addr_q;
        wr_en_d = 1'b0;
        wdata_d = wdata_q;
        f       = {bus.mem_rdata, lo_q};
        e       = f[14:10];

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RD_LO;
                    addr_d  = SRC_ADDR;
                    done_d  = 1'b0;
                end
            end
            RD_LO: begin
                state_d = RD_HI;
                addr_d  = SRC_ADDR + 8'd1;
            end
            RD_HI: begin
                lo_d    = bus.mem_rdata;
                state_d = DECODE;
            end
            DECODE: begin
                sgn_d  = f[15];
                sat_d  = 1'b0;
                left_d = 1'b0;
                cnt_d  = 4'd0;
                mag_d  = {5'd0, 1'b1, f[9:0]};
                if (e < E_MIN_5) begin
                    mag_d = 16'd0;
                end else if (e >= E_SAT_5) begin
                    sat_d = 1'b1;
                end else if (e < E_UNITY_5) begin
                    cnt_d = 4'(E_UNITY_5 - e);
                end else begin
                    left_d = 1'b1;
                    cnt_d  = 4'(e - E_UNITY_5);
                end
                state_d = (cnt_d == 4'd0) ? NEG : SHIFT;
            end
            SHIFT: begin
                // Right shifts drop low bits: truncation toward zero on the magnitude.
                mag_d = left_q ? (mag_q << 1) : (mag_q >> 1);
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_d = NEG;
            end
            NEG: begin
                res_d   = fix_result(sat_q, sgn_q, mag_q);
                state_d = WR_LO;
                addr_d  = DST_ADDR;
                wdata_d = res_d[7:0];
                wr_en_d = 1'b1;
            end
            WR_LO: begin
                state_d = WR_HI;
                addr_d  = DST_ADDR + 8'd1;
                wdata_d = res_q[15:8];
                wr_en_d = 1'b1;
            end
            WR_HI: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lo_q    <= 8'd0;
            mag_q   <= 16'd0;
            cnt_q   <= 4'd0;
            left_q  <= 1'b0;
            sat_q   <= 1'b0;
            sgn_q   <= 1'b0;
            res_q   <= 16'd0;
            done_q  <= 1'b0;
            addr_q  <= 8'd0;
            wr_en_q <= 1'b0;
            wdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            sat_q   <= sat_d;
            sgn_q   <= sgn_d;
            res_q   <= res_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            wr_en_q <= wr_en_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.done      = done_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wr_en = wr_en_q;
    assign bus.mem_wdata = wdata_q;

endmodule
